// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter
// Shares the single L1->L2 request/response port of the L2 between the L1
// instruction cache (I) and the L1 data cache (D). One requester is granted at
// a time, round-robin on contention, with at most one L2 transaction
// outstanding. Load responses are routed back to the requester that owns the
// transaction. Every output is driven from a register.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   i_req_*             I-cache request (valid held until i_req_ack pulse)
//   i_rsp_valid/data    I-cache load response (data bus shared with D)
//   d_req_*             D-cache request incl. store data
//   d_rsp_valid/data    D-cache load response (data bus shared with I)
//   l2_req_*            request to the L2 l1_mem_req_* port
//   l2_rsp_valid/data   response from the L2 l1_mem_rsp_* port
//
// Configuration
//   L2_ARB_PERF_EN      when defined, adds i_grant_cnt, d_grant_cnt and
//                       conflict_cnt (32-bit, wrapping) performance counters.
//                       Arbitration timing is the same in both builds.

module l2_req_arbiter #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 128,
    parameter logic [3:0]  LOAD_OP = 4'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              i_req_ack,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [3:0]        i_req_opcode,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ack,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [3:0]        d_req_opcode,
    input  logic [DATA_W-1:0] d_req_store_data,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              l2_req_valid,
    input  logic              l2_req_ack,
    output logic [ADDR_W-1:0] l2_req_addr,
    output logic [3:0]        l2_req_opcode,
    output logic [DATA_W-1:0] l2_req_store_data,
    input  logic              l2_rsp_valid,
    input  logic [DATA_W-1:0] l2_rsp_data
`ifdef L2_ARB_PERF_EN
    ,
    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    state_t            state_r;
    // 1 = I was granted last. Reset value 0 means "D last", so I wins the
    // first tie after reset.
    logic              last_grant_i_r;
    // Owner of the outstanding transaction: 1 = D, 0 = I.
    logic              owner_d_r;
    // Single response data register feeding both shared rsp_data buses.
    logic [DATA_W-1:0] rsp_data_r;

    logic              any_req_s;
    logic              grant_d_s;

    // Round-robin grant selection from the current requester valids.
    always_comb begin
        any_req_s = i_req_valid | d_req_valid;
        grant_d_s = 1'b0;
        if (i_req_valid && d_req_valid) begin
            grant_d_s = last_grant_i_r;
        end else if (d_req_valid) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Arbitration FSM with registered acks, L2 request and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            last_grant_i_r    <= 1'b0;
            owner_d_r         <= 1'b0;
            rsp_data_r        <= {DATA_W{1'b0}};
            i_req_ack         <= 1'b0;
            d_req_ack         <= 1'b0;
            i_rsp_valid       <= 1'b0;
            d_rsp_valid       <= 1'b0;
            l2_req_valid      <= 1'b0;
            l2_req_addr       <= {ADDR_W{1'b0}};
            l2_req_opcode     <= 4'd0;
            l2_req_store_data <= {DATA_W{1'b0}};
        end else begin
            // Acks and response valids are single-cycle pulses.
            i_req_ack   <= 1'b0;
            d_req_ack   <= 1'b0;
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        l2_req_valid <= 1'b1;
                        state_r      <= ST_REQ;
                        if (grant_d_s) begin
                            d_req_ack         <= 1'b1;
                            l2_req_addr       <= d_req_addr;
                            l2_req_opcode     <= d_req_opcode;
                            l2_req_store_data <= d_req_store_data;
                            owner_d_r         <= 1'b1;
                            last_grant_i_r    <= 1'b0;
                        end else begin
                            i_req_ack         <= 1'b1;
                            l2_req_addr       <= i_req_addr;
                            l2_req_opcode     <= i_req_opcode;
                            l2_req_store_data <= {DATA_W{1'b0}};
                            owner_d_r         <= 1'b0;
                            last_grant_i_r    <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Request held stable for as long as the L2 stalls
                    // (e.g. during a flush); there is no timeout.
                    if (l2_req_ack) begin
                        l2_req_valid <= 1'b0;
                        // Only loads get a response; everything else retires here.
                        if (l2_req_opcode == LOAD_OP) begin
                            state_r <= ST_WAIT_RSP;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT_RSP: begin
                    if (l2_rsp_valid) begin
                        rsp_data_r  <= l2_rsp_data;
                        i_rsp_valid <= ~owner_d_r;
                        d_rsp_valid <= owner_d_r;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_RSP;
                    end
                end
                default: begin
                    l2_req_valid <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rsp_data = rsp_data_r;
    assign d_rsp_data = rsp_data_r;

`ifdef L2_ARB_PERF_EN
    logic idle_s;
    assign idle_s = (state_r == ST_IDLE);

    // Grant and contention counters; all wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_grant_cnt  <= 32'd0;
            d_grant_cnt  <= 32'd0;
            conflict_cnt <= 32'd0;
        end else begin
            if (idle_s && any_req_s && !grant_d_s) begin
                i_grant_cnt <= i_grant_cnt + 32'd1;
            end
            if (idle_s && grant_d_s) begin
                d_grant_cnt <= d_grant_cnt + 32'd1;
            end
            if (idle_s && i_req_valid && d_req_valid) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter
// Directed testbench for l2_req_arbiter. The L2 side is driven by hand inside
// each scenario task; expected values are hand-computed constants. Inputs are
// driven and outputs sampled 1 ns after the rising clock edge.
// Define L2_ARB_PERF_EN to also exercise the performance counters.

module tb_l2_req_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic              clk;
    logic              reset;
    logic              i_req_valid;
    logic              i_req_ack;
    logic [ADDR_W-1:0] i_req_addr;
    logic [3:0]        i_req_opcode;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;
    logic              d_req_valid;
    logic              d_req_ack;
    logic [ADDR_W-1:0] d_req_addr;
    logic [3:0]        d_req_opcode;
    logic [DATA_W-1:0] d_req_store_data;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              l2_req_valid;
    logic              l2_req_ack;
    logic [ADDR_W-1:0] l2_req_addr;
    logic [3:0]        l2_req_opcode;
    logic [DATA_W-1:0] l2_req_store_data;
    logic              l2_rsp_valid;
    logic [DATA_W-1:0] l2_rsp_data;
`ifdef L2_ARB_PERF_EN
    logic [31:0]       i_grant_cnt;
    logic [31:0]       d_grant_cnt;
    logic [31:0]       conflict_cnt;
`endif

    int n_cmp;
    int n_err;

    localparam logic [DATA_W-1:0] RSP_A = 128'hDEAD_DEAD_DEAD_DEAD_BEEF_BEEF_BEEF_BEEF;
    localparam logic [DATA_W-1:0] RSP_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    l2_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_OP(4'd4)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ack(i_req_ack), .i_req_addr(i_req_addr),
        .i_req_opcode(i_req_opcode), .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ack(d_req_ack), .d_req_addr(d_req_addr),
        .d_req_opcode(d_req_opcode), .d_req_store_data(d_req_store_data),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .l2_req_valid(l2_req_valid), .l2_req_ack(l2_req_ack), .l2_req_addr(l2_req_addr),
        .l2_req_opcode(l2_req_opcode), .l2_req_store_data(l2_req_store_data),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data)
`ifdef L2_ARB_PERF_EN
        , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req_valid = 1'b0; i_req_addr = 32'h0; i_req_opcode = 4'd0;
        d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_opcode = 4'd0; d_req_store_data = 128'h0;
        l2_req_ack = 1'b0; l2_rsp_valid = 1'b0; l2_rsp_data = 128'h0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (l2_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_l2_req_valid: got %b want 0", l2_req_valid); end
        n_cmp++; if (l2_req_addr !== 32'h0) begin n_err++; $display("FAIL reset_l2_req_addr: got %h want 0", l2_req_addr); end
        n_cmp++; if ({i_req_ack, d_req_ack, i_rsp_valid, d_rsp_valid} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses: got %b want 0000", {i_req_ack, d_req_ack, i_rsp_valid, d_rsp_valid}); end
        n_cmp++; if (i_rsp_data !== 128'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", i_rsp_data); end
        n_cmp++; if ({l2_req_opcode, l2_req_store_data} !== 132'h0) begin n_err++; $display("FAIL reset_l2_op_data: got %h want 0", {l2_req_opcode, l2_req_store_data}); end
    endtask

    task automatic test_i_load();
        do_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_1040; i_req_opcode = 4'd4;
        tick();
        n_cmp++; if ({i_req_ack, d_req_ack, l2_req_valid} !== 3'b101) begin n_err++; $display("FAIL iload_grant: got %b want 101", {i_req_ack, d_req_ack, l2_req_valid}); end
        n_cmp++; if (l2_req_addr !== 32'h0000_1040) begin n_err++; $display("FAIL iload_addr: got %h want 00001040", l2_req_addr); end
        n_cmp++; if ({l2_req_opcode, l2_req_store_data} !== {4'd4, 128'h0}) begin n_err++; $display("FAIL iload_op_data: got %h want 4/0", {l2_req_opcode, l2_req_store_data}); end
        i_req_valid = 1'b0; l2_req_ack = 1'b1;
        tick();
        n_cmp++; if ({i_req_ack, l2_req_valid} !== 2'b00) begin n_err++; $display("FAIL iload_retire: got %b want 00", {i_req_ack, l2_req_valid}); end
        l2_req_ack = 1'b0;
        tick();
        n_cmp++; if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL iload_early_rsp: got %b want 00", {i_rsp_valid, d_rsp_valid}); end
        l2_rsp_valid = 1'b1; l2_rsp_data = RSP_A;
        tick();
        l2_rsp_valid = 1'b0; l2_rsp_data = 128'h0;
        n_cmp++; if ({i_rsp_valid, d_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL iload_rsp_valid: got %b want 10", {i_rsp_valid, d_rsp_valid}); end
        n_cmp++; if (i_rsp_data !== RSP_A || d_rsp_data !== RSP_A) begin n_err++; $display("FAIL iload_rsp_data: got %h/%h want %h", i_rsp_data, d_rsp_data, RSP_A); end
        tick();
        n_cmp++; if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL iload_rsp_pulse: got %b want 00", {i_rsp_valid, d_rsp_valid}); end
    endtask

    task automatic test_d_store_then_load();
        do_reset();
        d_req_valid = 1'b1; d_req_addr = 32'h8000_0010; d_req_opcode = 4'd7; d_req_store_data = 128'h1234;
        tick();
        n_cmp++; if ({i_req_ack, d_req_ack, l2_req_valid} !== 3'b011) begin n_err++; $display("FAIL dst_grant: got %b want 011", {i_req_ack, d_req_ack, l2_req_valid}); end
        n_cmp++; if ({l2_req_addr, l2_req_opcode, l2_req_store_data} !== {32'h8000_0010, 4'd7, 128'h1234}) begin n_err++; $display("FAIL dst_fields: got %h %h %h", l2_req_addr, l2_req_opcode, l2_req_store_data); end
        d_req_valid = 1'b0;
        tick();
        n_cmp++; if ({d_req_ack, l2_req_valid} !== 2'b01) begin n_err++; $display("FAIL dst_hold: got %b want 01", {d_req_ack, l2_req_valid}); end
        // Next D load presented while still in REQ: must not be sampled yet.
        l2_req_ack = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h8000_0020; d_req_opcode = 4'd4;
        tick();
        l2_req_ack = 1'b0;
        n_cmp++; if ({d_req_ack, l2_req_valid, d_rsp_valid} !== 3'b000) begin n_err++; $display("FAIL dst_retire: got %b want 000", {d_req_ack, l2_req_valid, d_rsp_valid}); end
        tick();
        n_cmp++; if ({d_req_ack, l2_req_valid, d_rsp_valid} !== 3'b110) begin n_err++; $display("FAIL dld_grant: got %b want 110", {d_req_ack, l2_req_valid, d_rsp_valid}); end
        n_cmp++; if ({l2_req_addr, l2_req_opcode} !== {32'h8000_0020, 4'd4}) begin n_err++; $display("FAIL dld_fields: got %h %h", l2_req_addr, l2_req_opcode); end
        d_req_valid = 1'b0; l2_req_ack = 1'b1;
        tick();
        l2_req_ack = 1'b0; l2_rsp_valid = 1'b1; l2_rsp_data = RSP_B;
        tick();
        l2_rsp_valid = 1'b0;
        n_cmp++; if ({i_rsp_valid, d_rsp_valid} !== 2'b01) begin n_err++; $display("FAIL dld_rsp_valid: got %b want 01", {i_rsp_valid, d_rsp_valid}); end
        n_cmp++; if (d_rsp_data !== RSP_B) begin n_err++; $display("FAIL dld_rsp_data: got %h want %h", d_rsp_data, RSP_B); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_i;
        logic [3:0] exp_d;
        logic [3:0] got_i;
        logic [3:0] got_d;
        do_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_0100; i_req_opcode = 4'd7;
        d_req_valid = 1'b1; d_req_addr = 32'h8000_0200; d_req_opcode = 4'd7; d_req_store_data = 128'h55;
        l2_req_ack = 1'b1;
        tick();
        n_cmp++; if ({i_req_ack, d_req_ack, l2_req_addr} !== {2'b10, 32'h0000_0100}) begin n_err++; $display("FAIL cont_first_i: got %b %h want 10 00000100", {i_req_ack, d_req_ack}, l2_req_addr); end
        // Grants land on every second edge: I, D, I, D from the first edge.
        exp_i = 4'b0101; exp_d = 4'b1010; got_i = 4'b0000; got_d = 4'b0000;
        got_i[0] = i_req_ack; got_d[0] = d_req_ack;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                got_i[k/2] = i_req_ack; got_d[k/2] = d_req_ack;
            end else begin
                n_cmp++; if ({i_req_ack, d_req_ack} !== 2'b00) begin n_err++; $display("FAIL cont_gap_%0d: got %b want 00", k, {i_req_ack, d_req_ack}); end
            end
        end
        n_cmp++; if (got_i !== exp_i || got_d !== exp_d) begin n_err++; $display("FAIL cont_alternate: got i=%b d=%b want i=%b d=%b", got_i, got_d, exp_i, exp_d); end
        i_req_valid = 1'b0; d_req_valid = 1'b0; l2_req_ack = 1'b0;
        tick(); tick();
    endtask

    task automatic test_delayed_ack();
        int bad;
        do_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_2080; i_req_opcode = 4'd4;
        tick();
        i_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 32'h8000_3000; d_req_opcode = 4'd7; d_req_store_data = 128'hAA;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (l2_req_valid !== 1'b1 || l2_req_addr !== 32'h0000_2080 || l2_req_opcode !== 4'd4 ||
                i_req_ack !== 1'b0 || d_req_ack !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL flush_stall: got %0d bad cycles want 0", bad); end
        l2_req_ack = 1'b1;
        tick();
        l2_req_ack = 1'b0;
        n_cmp++; if ({l2_req_valid, d_req_ack} !== 2'b00) begin n_err++; $display("FAIL flush_retire: got %b want 00", {l2_req_valid, d_req_ack}); end
        l2_rsp_valid = 1'b1; l2_rsp_data = RSP_A;
        tick();
        l2_rsp_valid = 1'b0;
        n_cmp++; if ({i_rsp_valid, d_rsp_valid, d_req_ack} !== 3'b100) begin n_err++; $display("FAIL flush_rsp: got %b want 100", {i_rsp_valid, d_rsp_valid, d_req_ack}); end
        tick();
        n_cmp++; if ({d_req_ack, l2_req_addr} !== {1'b1, 32'h8000_3000}) begin n_err++; $display("FAIL flush_next_d: got %b %h want 1 80003000", d_req_ack, l2_req_addr); end
        d_req_valid = 1'b0; l2_req_ack = 1'b1;
        tick();
        l2_req_ack = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        l2_rsp_valid = 1'b1; l2_rsp_data = RSP_B; l2_req_ack = 1'b1;
        tick();
        n_cmp++; if ({i_rsp_valid, d_rsp_valid, l2_req_valid} !== 3'b000) begin n_err++; $display("FAIL spurious_1: got %b want 000", {i_rsp_valid, d_rsp_valid, l2_req_valid}); end
        tick();
        n_cmp++; if ({i_rsp_valid, d_rsp_valid, i_rsp_data} !== {2'b00, 128'h0}) begin n_err++; $display("FAIL spurious_2: got %b %h want 00 0", {i_rsp_valid, d_rsp_valid}, i_rsp_data); end
        l2_rsp_valid = 1'b0; l2_req_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_req_valid = 1'b1; d_req_addr = 32'h8000_4000; d_req_opcode = 4'd4;
        tick();
        d_req_valid = 1'b0; l2_req_ack = 1'b1;
        tick();
        l2_req_ack = 1'b0;
        // Now waiting for the response; reset abandons it.
        reset = 1'b1; l2_rsp_valid = 1'b1; l2_rsp_data = RSP_A;
        tick();
        reset = 1'b0; l2_rsp_valid = 1'b0;
        n_cmp++; if ({l2_req_valid, d_rsp_valid, i_rsp_valid, d_req_ack} !== 4'b0000) begin n_err++; $display("FAIL rstmid_clear: got %b want 0000", {l2_req_valid, d_rsp_valid, i_rsp_valid, d_req_ack}); end
        d_req_valid = 1'b1; d_req_addr = 32'h8000_5000; d_req_opcode = 4'd4;
        tick();
        n_cmp++; if ({d_req_ack, l2_req_valid, l2_req_addr} !== {2'b11, 32'h8000_5000}) begin n_err++; $display("FAIL rstmid_regrant: got %b %h", {d_req_ack, l2_req_valid}, l2_req_addr); end
        d_req_valid = 1'b0; l2_req_ack = 1'b1;
        tick();
        l2_req_ack = 1'b0; l2_rsp_valid = 1'b1; l2_rsp_data = RSP_B;
        tick();
        l2_rsp_valid = 1'b0;
        n_cmp++; if ({d_rsp_valid, i_rsp_valid, d_rsp_data} !== {2'b10, RSP_B}) begin n_err++; $display("FAIL rstmid_rsp: got %b %h", {d_rsp_valid, i_rsp_valid}, d_rsp_data); end
    endtask

`ifdef L2_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        i_req_addr = 32'h10; i_req_opcode = 4'd7; d_req_addr = 32'h20; d_req_opcode = 4'd7;
        l2_req_ack = 1'b1;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        tick();                          // conflict, I granted
        i_req_valid = 1'b0;
        tick();                          // retire
        tick();                          // D granted alone
        d_req_valid = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            i_req_valid = 1'b1; tick();  // I granted alone
            i_req_valid = 1'b0; tick();
        end
        d_req_valid = 1'b1; tick();      // D granted alone
        d_req_valid = 1'b0; tick();
        l2_req_ack = 1'b0;
        n_cmp++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== {32'd3, 32'd2, 32'd1}) begin n_err++; $display("FAIL perf_counts: got %0d/%0d/%0d want 3/2/1", i_grant_cnt, d_grant_cnt, conflict_cnt); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_i_load();
        test_d_store_then_load();
        test_contention();
        test_delayed_ack();
        test_spurious();
        test_reset_mid();
`ifdef L2_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
